// File: rtl/mux_nx1_stream_pkg.sv
// Shared constants and types for the N-input registered stream multiplexer.
package mux_nx1_stream_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_IN  = 4;
  localparam int DEF_SEL_W = 2;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Index following idx in a ring of n channels.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_nx1_stream_if.sv
// Handshake bundle of mux_nx1_stream: N input channels, one output channel, status.
interface mux_nx1_stream_if import mux_nx1_stream_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_IN  = DEF_N_IN,
  parameter int SEL_W = DEF_SEL_W,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic [SEL_W-1:0]      sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SEL_W-1:0]      out_src;
  logic                  sel_err;
  logic [CNT_W-1:0]      xfer_cnt;

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_src, sel_err, xfer_cnt
  );

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_src, sel_err, xfer_cnt
  );

endinterface

// File: rtl/mux_nx1_stream_mux.sv
// Combinational N_IN x WIDTH select mux; an out-of-range select yields zero.
module mux_nx1_w #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [WIDTH-1:0]      data_o
);

  // NOTE: assigning a default before the loop keeps every path driven, so no latch is inferred.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel_i == SEL_W'(i)) data_o = data_i[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// Registered N:1 stream mux with valid/ready, source tag, transfer count and select error.
// Define MUX_RR_AUTO_SEL_EN to replace the external select with round-robin arbitration.
module mux_nx1_stream import mux_nx1_stream_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_IN  = DEF_N_IN,
  parameter int SEL_W = DEF_SEL_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic              clk,
  input logic              reset,
  mux_nx1_stream_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] src_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic             can_load;
  logic             sel_ok;
  logic             err_d;
  logic             accept;
  logic [SEL_W-1:0] active_sel;
  logic [N_IN-1:0]  in_ready_d;
  logic [WIDTH-1:0] mux_data;

  // A held word can be replaced in the same cycle it is taken downstream.
  assign can_load = (state_q == ST_EMPTY) | bus.out_ready;

`ifdef MUX_RR_AUTO_SEL_EN
  logic [SEL_W-1:0] rr_q;

  // Pick the valid channel at the smallest ring distance from rr_q.
  always_comb begin
    int d;
    int best_d;
    d          = 0;
    best_d     = N_IN;
    active_sel = rr_q;
    sel_ok     = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      d = (i + N_IN - int'(rr_q)) % N_IN;
      if (bus.in_valid[i] && d < best_d) begin
        best_d     = d;
        active_sel = SEL_W'(i);
        sel_ok     = 1'b1;
      end
    end
    err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)       rr_q <= '0;
    else if (accept) rr_q <= SEL_W'(rr_next(int'(active_sel), N_IN));
  end
`else
  always_comb begin
    active_sel = bus.sel;
    sel_ok     = (int'(bus.sel) < N_IN);
    err_d      = can_load & ~sel_ok;
  end
`endif

  always_comb begin
    in_ready_d = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_ready_d[i] = ~reset & can_load & sel_ok & (active_sel == SEL_W'(i));
    end
  end

  assign accept = |(bus.in_valid & in_ready_d);

  mux_nx1_w #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_mux (
    .data_i (bus.in_data),
    .sel_i  (active_sel),
    .data_o (mux_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      err_q <= err_d;
      case (state_q)
        ST_EMPTY: begin
          if (accept) state_q <= ST_FULL;
        end
        ST_FULL: begin
          if (!accept && bus.out_ready) state_q <= ST_EMPTY;
        end
        default: state_q <= ST_EMPTY;
      endcase
      if (accept) begin
        data_q <= mux_data;
        src_q  <= active_sel;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_src   = src_q;
  assign bus.sel_err   = err_q;
  assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Scoreboard bench for mux_nx1_stream: default instance plus N_IN=3 and CNT_W=4 variants.
module tb_mux_nx1_stream;
  import mux_nx1_stream_pkg::*;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } word_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mux_nx1_stream_if #(.WIDTH(8), .N_IN(4), .SEL_W(2), .CNT_W(16)) bus_a ();
  mux_nx1_stream_if #(.WIDTH(8), .N_IN(3), .SEL_W(2), .CNT_W(16)) bus_b ();
  mux_nx1_stream_if #(.WIDTH(8), .N_IN(4), .SEL_W(2), .CNT_W(4))  bus_c ();

  mux_nx1_stream #(.WIDTH(8), .N_IN(4), .SEL_W(2), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  mux_nx1_stream #(.WIDTH(8), .N_IN(3), .SEL_W(2), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );
  mux_nx1_stream #(.WIDTH(8), .N_IN(4), .SEL_W(2), .CNT_W(4)) u_dut_c (
    .clk(clk), .reset(reset), .bus(bus_c)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  word_t       sb_q[$];
  logic        m_full;
  logic [15:0] m_cnt;
  int          m_rr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    bus_a.in_data = '0; bus_a.in_valid = '0; bus_a.sel = '0; bus_a.out_ready = 1'b1;
    bus_b.in_data = '0; bus_b.in_valid = '0; bus_b.sel = '0; bus_b.out_ready = 1'b1;
    bus_c.in_data = '0; bus_c.in_valid = '0; bus_c.sel = '0; bus_c.out_ready = 1'b1;
  endtask

  // One clock of the default instance: compare against the model, then advance it.
  task automatic cycle();
    logic       cl, ok, acc, ordy, rst;
    int         act;
    logic [3:0] exp_rdy, vld;
    word_t      w;
    #1;
    check("out_valid", 32'(bus_a.out_valid), 32'(m_full));
    check("xfer_cnt", 32'(bus_a.xfer_cnt), 32'(m_cnt));
    check("sel_err", 32'(bus_a.sel_err), 32'd0);
    if (m_full) begin
      w = sb_q[0];
      check("out_data", 32'(bus_a.out_data), 32'(w.data));
      check("out_src", 32'(bus_a.out_src), 32'(w.src));
    end
    vld  = bus_a.in_valid;
    ordy = bus_a.out_ready;
    rst  = reset;
    cl   = !m_full || ordy;
`ifdef MUX_RR_AUTO_SEL_EN
    ok  = 1'b0;
    act = 0;
    for (int k = 0; k < 4; k++) begin
      if (!ok && vld[(m_rr + k) % 4]) begin
        act = (m_rr + k) % 4;
        ok  = 1'b1;
      end
    end
`else
    ok  = 1'b1;
    act = int'(bus_a.sel);
`endif
    exp_rdy = (!rst && cl && ok) ? (4'b0001 << act) : 4'b0000;
    check("in_ready", 32'(bus_a.in_ready), 32'(exp_rdy));
    acc    = exp_rdy[act] && vld[act];
    w.src  = 2'(act);
    w.data = bus_a.in_data[act*8 +: 8];
    @(posedge clk);
    if (rst) begin
      m_full = 1'b0;
      m_cnt  = '0;
      m_rr   = 0;
      sb_q.delete();
    end else begin
      if (m_full && ordy) sb_q.delete(0);
      if (acc) begin
        sb_q.push_back(w);
        m_full = 1'b1;
        m_cnt++;
        m_rr = (act + 1) % 4;
      end else if (ordy) begin
        m_full = 1'b0;
      end
    end
    @(negedge clk);
  endtask

`ifdef MUX_RR_AUTO_SEL_EN
  int rr_exp [5] = '{0, 1, 2, 3, 0};
`endif

  initial begin
    m_full = 1'b0;
    m_cnt  = '0;
    m_rr   = 0;
    idle_all();
    reset          = 1'b1;
    bus_a.in_valid = 4'hF;
    @(negedge clk);
    @(negedge clk);
    cycle();                       // reset still high: in_ready must be zero
    reset = 1'b0;

    // Single transfer from channel 2
    bus_a.sel = 2'd2; bus_a.in_valid = 4'b0100; bus_a.in_data = 32'h00A5_0000;
    cycle();
    check("t1_data", 32'(bus_a.out_data), 32'h0000_00A5);
    check("t1_src", 32'(bus_a.out_src), 32'd2);
    check("t1_valid", 32'(bus_a.out_valid), 32'd1);
    check("t1_cnt", 32'(bus_a.xfer_cnt), 32'd1);
    bus_a.in_valid = '0;
    cycle();

    // Backpressure: hold 0x3C while channel 1 waits
    bus_a.sel = 2'd0; bus_a.in_valid = 4'b0001; bus_a.in_data = 32'h0000_003C;
    cycle();
    bus_a.out_ready = 1'b0; bus_a.sel = 2'd1; bus_a.in_valid = 4'b0010;
    bus_a.in_data = 32'h0000_7700;
    repeat (5) cycle();
    check("bp_hold", 32'(bus_a.out_data), 32'h0000_003C);
    bus_a.out_ready = 1'b1;
    cycle();
    check("bp_release", 32'(bus_a.out_data), 32'h0000_0077);
    check("bp_nobubble", 32'(bus_a.out_valid), 32'd1);
    bus_a.in_valid = '0;
    cycle();

    // Back-to-back from a fresh reset
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    bus_a.in_valid = 4'hF; bus_a.in_data = 32'h1312_1110;
    for (int s = 0; s < 4; s++) begin
      bus_a.sel = 2'(s);
      cycle();
      check("b2b_data", 32'(bus_a.out_data), 32'h10 + 32'(s));
    end
    check("b2b_cnt", 32'(bus_a.xfer_cnt), 32'd4);
    bus_a.in_valid = '0;
    cycle();

    // Reset while FULL and stalled
    bus_a.sel = 2'd0; bus_a.in_valid = 4'b0001; bus_a.in_data = 32'h0000_005A;
    cycle();
    bus_a.out_ready = 1'b0; bus_a.in_valid = '0; reset = 1'b1;
    cycle();
    reset = 1'b0; bus_a.out_ready = 1'b1;
    check("rst_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_data", 32'(bus_a.out_data), 32'd0);
    check("rst_cnt", 32'(bus_a.xfer_cnt), 32'd0);

    // CNT_W=4 instance: 16 accepts wrap the counter
    bus_c.sel = 2'd0; bus_c.in_valid = 4'b0001; bus_c.in_data = 32'h0000_0001;
    repeat (15) cycle();
    check("c_cnt15", 32'(bus_c.xfer_cnt), 32'd15);
    cycle();
    check("c_wrap", 32'(bus_c.xfer_cnt), 32'd0);
    bus_c.in_valid = '0;

`ifndef MUX_RR_AUTO_SEL_EN
    // N_IN=3 instance: select 3 is out of range
    bus_b.sel = 2'd3; bus_b.in_valid = 3'b111; bus_b.in_data = 24'h33_2211;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("b_oor_rdy", 32'(bus_b.in_ready), 32'd0);
      cycle();
      check("b_oor_err", 32'(bus_b.sel_err), 32'd1);
      check("b_oor_valid", 32'(bus_b.out_valid), 32'd0);
      check("b_oor_cnt", 32'(bus_b.xfer_cnt), 32'd0);
    end
    bus_b.sel = 2'd1;
    #1;
    check("b_rdy", 32'(bus_b.in_ready), 32'b010);
    cycle();
    check("b_err_clr", 32'(bus_b.sel_err), 32'd0);
    check("b_data", 32'(bus_b.out_data), 32'h22);
    check("b_src", 32'(bus_b.out_src), 32'd1);
    check("b_cnt", 32'(bus_b.xfer_cnt), 32'd1);
    bus_b.out_ready = 1'b0; bus_b.sel = 2'd3;
    cycle();
    check("b_err_gated", 32'(bus_b.sel_err), 32'd0);
    check("b_hold", 32'(bus_b.out_data), 32'h22);
    bus_b.out_ready = 1'b1; bus_b.in_valid = '0; bus_b.sel = 2'd0;
    cycle();
`else
    // Round-robin order with every channel requesting
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    bus_a.in_valid = 4'hF; bus_a.in_data = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rr_src", 32'(bus_a.out_src), 32'(rr_exp[i]));
    end
    bus_a.in_valid = 4'b1001;
    cycle();
    check("rr_skip3", 32'(bus_a.out_src), 32'd3);
    cycle();
    check("rr_wrap0", 32'(bus_a.out_src), 32'd0);
    bus_a.in_valid = '0;
    cycle();
`endif

    // Random traffic against the model
    repeat (300) begin
      bus_a.sel       = 2'($urandom_range(0, 3));
      bus_a.in_valid  = 4'($urandom);
      bus_a.in_data   = $urandom;
      bus_a.out_ready = ($urandom_range(0, 9) < 7);
      reset           = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0;
    idle_all();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
